// File: rtl/order_entry_if.sv
// Seller-side order/response channel of the order entry front end.
//   order_valid  : order presented, held until the seller replies or the wait times out
//   order_choice : item code driven to the seller's choice input
//   order_money  : credit driven to the seller's money input
//   resp_valid   : seller reply strobe
//   resp_item    : item dispensed (0 = none)
//   resp_avail   : seller availability code for the chosen item
//   resp_change  : remaining money returned by the seller
// master = order_entry, slave = seller core.
interface order_entry_if;
  logic       order_valid;
  logic [2:0] order_choice;
  logic [2:0] order_money;
  logic       resp_valid;
  logic [2:0] resp_item;
  logic [2:0] resp_avail;
  logic [2:0] resp_change;

  modport master (
    output order_valid, order_choice, order_money,
    input  resp_valid, resp_item, resp_avail, resp_change
  );

  modport slave (
    input  order_valid, order_choice, order_money,
    output resp_valid, resp_item, resp_avail, resp_change
  );
endinterface

// File: rtl/order_entry.sv
// Customer-side front end for the food seller core.
// Accumulates coins into a credit, captures a food selection, presents one
// (choice, money) order to the seller and pays out the returned change one
// unit per change_pulse.
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   coin_pulse    : coin inserted strobe, coin_value = coin value in units
//   sel_pulse     : keypad strobe, sel_code 1..7 = item, 0 = cancel/refund
//   bus           : order/response channel to the seller (master side)
//   credit        : current credit for the display
//   coin_reject   : one-cycle pulse when a coin is refused
//   change_pulse  : one-cycle pulse per unit of change paid out
//   item_out      : last dispensed item, held until the next order
//   avail_out     : last availability code, held until the next order
//   busy          : high while an order or payout is in progress
module order_entry #(
  parameter int unsigned MAX_CREDIT   = 7,
  parameter int unsigned RESP_TIMEOUT = 16,
  parameter int unsigned PAY_GAP      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_pulse,
  input  logic [2:0]    coin_value,
  input  logic          sel_pulse,
  input  logic [2:0]    sel_code,
  order_entry_if.master bus,
  output logic [2:0]    credit,
  output logic          coin_reject,
  output logic          change_pulse,
  output logic [2:0]    item_out,
  output logic [2:0]    avail_out,
  output logic          busy
);

  localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned GW = $clog2(PAY_GAP + 1);

  typedef enum logic [1:0] {IDLE, ORDER, WAIT, PAYOUT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    credit_q, credit_d;
  logic [2:0]    choice_q, choice_d;
  logic [2:0]    money_q, money_d;
  logic          valid_q, valid_d;
  logic [2:0]    payout_q, payout_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    item_q, item_d;
  logic [2:0]    avail_q, avail_d;
  logic          reject_q, reject_d;

  logic [3:0]    coin_sum;
  logic          coin_ok;
  logic [2:0]    credit_eff;
  logic [2:0]    resp_pay;
  logic          pay_now;

  // Coin is applied before a same-cycle selection, so the order sees credit_eff.
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_ok    = coin_pulse && (coin_value != '0) && (coin_sum <= 4'(MAX_CREDIT));
  assign credit_eff = coin_ok ? coin_sum[2:0] : credit_q;

  // The seller can never return more than it was given.
  assign resp_pay = (bus.resp_change > money_q) ? money_q : bus.resp_change;

  assign pay_now = (state_q == PAYOUT) && (gap_q == '0) && (payout_q != '0);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    choice_d = choice_q;
    money_d  = money_q;
    valid_d  = valid_q;
    payout_d = payout_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    item_d   = item_q;
    avail_d  = avail_q;
    reject_d = coin_pulse && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        reject_d = coin_pulse && (coin_value != '0) && !coin_ok;
        credit_d = credit_eff;
        if (sel_pulse && (credit_eff != '0)) begin
          if (sel_code != '0) begin
            choice_d = sel_code;
            money_d  = credit_eff;
            item_d   = '0;
            avail_d  = '0;
            state_d  = ORDER;
          end else begin
            payout_d = credit_eff;
            credit_d = '0;
            gap_d    = '0;
            state_d  = PAYOUT;
          end
        end
      end

      // order_valid is registered here, giving a two-cycle select-to-valid latency.
      ORDER: begin
        valid_d = 1'b1;
        timer_d = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.resp_valid) begin
          item_d   = bus.resp_item;
          avail_d  = bus.resp_avail;
          payout_d = resp_pay;
          credit_d = '0;
          valid_d  = 1'b0;
          gap_d    = '0;
          state_d  = (resp_pay != '0) ? PAYOUT : IDLE;
        end else if (timer_q == TW'(RESP_TIMEOUT - 1)) begin
          item_d   = '0;
          payout_d = money_q;
          credit_d = '0;
          valid_d  = 1'b0;
          gap_d    = '0;
          state_d  = PAYOUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      PAYOUT: begin
        if (pay_now) begin
          payout_d = payout_q - 3'd1;
          gap_d    = GW'(PAY_GAP);
          if (payout_q == 3'd1) state_d = IDLE;
        end else if (payout_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      choice_q <= '0;
      money_q  <= '0;
      valid_q  <= 1'b0;
      payout_q <= '0;
      timer_q  <= '0;
      gap_q    <= '0;
      item_q   <= '0;
      avail_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      choice_q <= choice_d;
      money_q  <= money_d;
      valid_q  <= valid_d;
      payout_q <= payout_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
      item_q   <= item_d;
      avail_q  <= avail_d;
      reject_q <= reject_d;
    end
  end

  assign bus.order_valid  = valid_q;
  assign bus.order_choice = choice_q;
  assign bus.order_money  = money_q;
  assign credit           = credit_q;
  assign coin_reject      = reject_q;
  assign change_pulse     = pay_now;
  assign item_out         = item_q;
  assign avail_out        = avail_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: doc/order_entry.md
Name: order_entry

Overview:
- Customer-side front end for the food seller core.
- Accumulates inserted coins into a credit, captures a food selection, and presents one order to the seller as a (choice, money) request with a valid/response handshake.
- Takes the seller's reply (item, availability, remaining money) and pays out change one unit per pulse.
- Sits between the coin/keypad I/O and the seller core's choice/money inputs and item/available/remaining outputs.

Parameters:
- MAX_CREDIT, 7, maximum credit in units; must fit in 3 bits.
- RESP_TIMEOUT, 16, cycles to wait for resp_valid before aborting and refunding the full credit.
- PAY_GAP, 2, idle cycles between successive change_pulse outputs (minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_pulse  in  1  one-cycle strobe: a coin was inserted.
- coin_value  in  3  value of the coin in units; sampled with coin_pulse.
- sel_pulse  in  1  one-cycle strobe: a keypad button was pressed.
- sel_code  in  3  button code; 1..7 = food item, 0 = cancel/refund.
- order_valid  out  1  order presented to the seller; held until resp_valid.
- order_choice  out  3  item code sent to the seller (drives the seller's choice input).
- order_money  out  3  credit sent to the seller (drives the seller's money input).
- resp_valid  in  1  seller reply strobe.
- resp_item  in  3  item dispensed (0 = none).
- resp_avail  in  3  seller availability code for the chosen item; latched for display.
- resp_change  in  3  remaining money returned by the seller.
- credit  out  3  current credit, for the display.
- coin_reject  out  1  one-cycle pulse: the coin was refused.
- change_pulse  out  1  one-cycle pulse per unit of change paid out.
- item_out  out  3  last dispensed item, held until the next order.
- avail_out  out  3  last resp_avail, held until the next order.
- busy  out  1  high in ORDER, WAIT and PAYOUT.

Behaviour:
- Reset: all outputs 0; state IDLE; payout and timeout counters 0. Reset takes effect in any state and discards any in-flight order and pending change without paying it out.
- States: IDLE, ORDER, WAIT, PAYOUT.
- IDLE, coin_pulse: if credit + coin_value <= MAX_CREDIT, credit updates on the next edge. Otherwise credit is unchanged and coin_reject pulses for exactly 1 cycle. The sum is computed 4 bits wide, so no wrap-around. coin_value = 0 is a no-op.
- IDLE, sel_pulse with sel_code 1..7 and credit > 0: latch order_choice = sel_code and order_money = credit; go to ORDER next cycle.
- IDLE, sel_pulse with credit = 0: ignored.
- IDLE, sel_code 0 with credit > 0: load payout = credit; go to PAYOUT.
- IDLE, coin_pulse and sel_pulse in the same cycle: the coin is applied first, and the order uses the updated credit.
- ORDER: order_valid = 1 and busy = 1; go to WAIT next cycle. order_valid stays high through WAIT.
- ORDER/WAIT/PAYOUT, coin_pulse: the coin is refused with coin_reject, and credit is unchanged.
- ORDER/WAIT/PAYOUT, sel_pulse: ignored.
- WAIT, resp_valid: latch item_out = resp_item, avail_out = resp_avail, payout = resp_change; clear credit; deassert order_valid the following cycle.
  - If resp_change > 0, go to PAYOUT; else go to IDLE.
  - resp_change > order_money is clamped to order_money.
- WAIT, timeout: after RESP_TIMEOUT cycles with no resp_valid, set item_out = 0, payout = order_money, clear credit, and go to PAYOUT.
- resp_valid outside WAIT: ignored.
- PAYOUT: first change_pulse occurs in the cycle after entry. Subsequent pulses are separated by PAY_GAP low cycles. Each pulse decrements payout. When payout reaches 0, go to IDLE. The number of pulses equals the payout exactly.
- Latency: sel_pulse to order_valid high = 2 cycles.

Test Plan:
- Reset, coins 2 and 4, select 1, seller replies item 1 / avail 3 / change 2 → credit 6, order_valid with order_choice = 1 and order_money = 6, item_out = 1, avail_out = 3, exactly 2 change_pulses separated by 2 low cycles, credit 0, back to IDLE.
- Credit 5, coin 4 → coin_reject for 1 cycle, credit stays 5; then coin 2 → credit 7.
- Credit 3, sel_code 0 → 3 change_pulses, no order_valid, credit 0.
- Credit 7, select 3, no resp_valid for 16 cycles → order_valid drops, item_out = 0, 7 change_pulses.
- Coin 3 and select 2 in the same cycle from credit 1 → order_money = 4; a coin during WAIT → coin_reject, and order_money stays 4.
- rst asserted mid-PAYOUT after 1 of 4 pulses → no further pulses; all outputs 0 on the next cycle.
